uart_tx_io: RTL and testbench

//  Memory-mapped UART transmitter on the CPU IO bus; the output counterpart of the switch input port.
//  CPU sw to the data address queues one byte, serialised 8N1 on tx (LSB first).
//  CPU lw from the status address reports busy/full/overflow so software can poll before writing.

---
 rtl/uart_tx_io_if.sv | 20 ++
 rtl/uart_tx_io.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_io.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_io_if.sv
// CPU IO-bus view of the UART transmitter: decode select, strobes, address, data and serial line.
interface uart_tx_io_if;
    logic        UARTCtrl;
    logic        ioWrite;
    logic        ioRead;
    logic [1:0]  uartAddr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        tx;

    modport master (
        output UARTCtrl, ioWrite, ioRead, uartAddr, write_data,
        input  read_data, tx
    );

    modport slave (
        input  UARTCtrl, ioWrite, ioRead, uartAddr, write_data,
        output read_data, tx
    );
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with pollable status {ovf, full, busy}.
// Define UART_TX_FIFO_EN for a 4-entry transmit FIFO instead of a single holding register.
module uart_tx_io #(
    parameter int unsigned CLK_FREQ = 23_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input logic         clock,
    input logic         reset,
    uart_tx_io_if.slave bus
);
    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;

    logic       wr_req, rd_req, push, pop;
    logic       buf_empty, buf_full, busy;
    logic [7:0] head;
    logic       unused_wdata;

    assign wr_req       = bus.UARTCtrl & bus.ioWrite & (bus.uartAddr == 2'b00);
    assign rd_req       = bus.UARTCtrl & bus.ioRead & (bus.uartAddr == 2'b10);
    // A pop on the same edge frees a slot, so a write to a full buffer still lands.
    assign push         = wr_req & (~buf_full | pop);
    assign unused_wdata = ^bus.write_data[15:8];

`ifdef UART_TX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;

    assign buf_empty = (count_q == 3'd0);
    assign buf_full  = (count_q == 3'd4);
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.write_data[7:0];
    end
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    assign buf_empty = ~hold_vld_q;
    assign buf_full  = hold_vld_q;
    assign head      = hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
        end else if (push) begin
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) hold_q <= bus.write_data[7:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = 3'd0;
                if (!buf_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!buf_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Overflow set wins over the read-clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (rd_req) ovf_d = 1'b0;
        if (wr_req && buf_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy          = (state_q != StIdle) | ~buf_empty;
    assign bus.read_data = rd_req ? {13'd0, ovf_q, buf_full, busy} : 16'd0;
    assign bus.tx        = tx_q;
endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: serial-line monitor with byte scoreboard, bus decode vector table,
// and hand-timed sequences for latency, back-to-back frames, overflow and mid-frame reset.
module tb_uart_tx_io;
    localparam int unsigned Clks = 8;
`ifdef UART_TX_FIFO_EN
    localparam int Depth = 4;
`else
    localparam int Depth = 1;
`endif

    typedef struct {
        logic        ctrl;
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_stat;
        logic        push;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_tx_io_if bus ();

    uart_tx_io #(
        .CLK_FREQ(8),
        .BAUD    (1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_frames = 0;
    logic [7:0] sb[$];
    logic       mon_busy = 1'b0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.UARTCtrl   = 1'b0;
        bus.ioWrite    = 1'b0;
        bus.ioRead     = 1'b0;
        bus.uartAddr   = 2'b00;
        bus.write_data = 16'h0000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic ctrl, input logic [1:0] addr, input logic [15:0] d);
        bus.UARTCtrl   = ctrl;
        bus.ioWrite    = 1'b1;
        bus.uartAddr   = addr;
        bus.write_data = d;
        step(1);
        idle_bus();
    endtask

    // Samples status as it stands before the next edge, then lets that edge take the read.
    task automatic read_status(output logic [15:0] d);
        bus.UARTCtrl = 1'b1;
        bus.ioRead   = 1'b1;
        bus.uartAddr = 2'b10;
        #1;
        d = bus.read_data;
        step(1);
        idle_bus();
    endtask

    task automatic drain(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (sb.size() == 0 && !mon_busy) break;
            step(1);
        end
        check("drain timeout", 16'(i < max_cyc), 16'd1);
        step(2);
    endtask

    // Frame decoder: start detected on the first low cycle, bits sampled mid-bit.
    initial begin : monitor
        logic [7:0] data;
        logic       start_ok, stop_ok, aborted;
        forever begin
            @(negedge clock);
            if (!reset && bus.tx === 1'b0) begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                data     = 8'h00;
                start_ok = 1'b0;
                stop_ok  = 1'b0;
                for (int off = 1; off < 10 * Clks; off++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off == Clks / 2) begin
                        start_ok = (bus.tx === 1'b0);
                    end else if (off % Clks == Clks / 2) begin
                        if (off / Clks <= 8) data[off/Clks-1] = bus.tx;
                        else stop_ok = (bus.tx === 1'b1);
                    end
                end
                if (!aborted) begin
                    n_frames++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected frame: got %h, expected no frame", data);
                    end else begin
                        check("frame data", {8'h00, data}, {8'h00, sb.pop_front()});
                    end
                    check("frame start/stop", {14'd0, start_ok, stop_ok}, 16'h0003);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] st;
        int          frames_before;
        vec_t        vecs[10];

        vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h0012, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd1, 16'h0034, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0056, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0078, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'hAB5A, 16'h0000,
                    (Depth == 1) ? 16'h0003 : 16'h0001, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0001, 16'h0001, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 16'h0001, 1'b0};

        idle_bus();
        reset = 1'b1;
        step(3);
        check("reset tx", {15'd0, bus.tx}, 16'h0001);
        reset = 1'b0;
        read_status(st);
        check("reset status", st, 16'h0000);

        // Single frame: latency and frame length
        step(2);
        sb.push_back(8'hA5);
        bus_write(1'b1, 2'b00, 16'h00A5);
        check("tx high at write edge", {15'd0, bus.tx}, 16'h0001);
        step(1);
        check("tx low next edge", {15'd0, bus.tx}, 16'h0000);
        step(79);
        read_status(st);
        check("busy at end of frame", st, 16'h0001);
        read_status(st);
        check("idle after 80 clks", st, 16'h0000);

        // Back-to-back frames with no gap
        step(2);
        sb.push_back(8'h55);
        bus_write(1'b1, 2'b00, 16'h0055);
        step(4);
        sb.push_back(8'h0F);
        bus_write(1'b1, 2'b00, 16'h000F);
        step(155);
        read_status(st);
        check("busy at 160 clks", st, 16'h0001);
        read_status(st);
        check("idle after 160 clks", st, 16'h0000);

        // Fill buffer, overflow, sticky ovf cleared by read, write coinciding with pop
        step(2);
        sb.push_back(8'hC3);
        bus_write(1'b1, 2'b00, 16'h00C3);
        step(1);
        for (int i = 0; i < Depth; i++) begin
            sb.push_back(8'h10 + 8'(i));
            bus_write(1'b1, 2'b00, 16'h0010 + 16'(i));
        end
        bus_write(1'b1, 2'b00, 16'h00FF);
        read_status(st);
        check("overflow status", st, 16'h0007);
        read_status(st);
        check("ovf cleared by read", st, 16'h0003);
        step(80 - (4 + Depth));
        sb.push_back(8'h81);
        bus_write(1'b1, 2'b00, 16'h0081);
        read_status(st);
        check("write on pop edge accepted", st, 16'h0003);
        drain(2000);
        read_status(st);
        check("idle after overflow test", st, 16'h0000);

        // Reset in the middle of the first data bit discards everything
        step(2);
        frames_before = n_frames;
        bus_write(1'b1, 2'b00, 16'h003C);
        bus_write(1'b1, 2'b00, 16'h0096);
        step(12);
        check("tx low in data bit 0", {15'd0, bus.tx}, 16'h0000);
        reset = 1'b1;
        step(1);
        check("tx high after mid-frame reset", {15'd0, bus.tx}, 16'h0001);
        reset = 1'b0;
        read_status(st);
        check("status after mid-frame reset", st, 16'h0000);
        step(200);
        check("no frames after reset", 16'(n_frames), 16'(frames_before));

        // Bus decode table
        step(2);
        for (int i = 0; i < 10; i++) begin
            bus.UARTCtrl   = vecs[i].ctrl;
            bus.ioWrite    = vecs[i].wr;
            bus.ioRead     = vecs[i].rd;
            bus.uartAddr   = vecs[i].addr;
            bus.write_data = vecs[i].wdata;
            if (vecs[i].push) sb.push_back(vecs[i].wdata[7:0]);
            #1;
            check($sformatf("vec%0d read_data", i), bus.read_data, vecs[i].exp_rd);
            step(1);
            idle_bus();
            read_status(st);
            check($sformatf("vec%0d status", i), st, vecs[i].exp_stat);
        end
        drain(2000);

        check("scoreboard empty", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
